// File: rtl/boot_stream_loader.sv
// Boot streamer: reads a boot image from synchronous memory, emits the boot packet
// sequence one packet per cycle, then turns the core's error outputs into a sticky verdict.
module boot_stream_loader #(
  parameter int unsigned MEM_ADDR_W  = 11,
  parameter int unsigned HEADER_ADDR = 1,
  parameter int unsigned BODY_BASE   = 2,
  parameter int unsigned MAX_PROGRAM = 512,
  parameter int unsigned PKT_ADDR_W  = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           epilogue_length,
  input  logic [15:0]           sleep_length,
  input  logic [15:0]           countdown,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [15:0]           mem_rdata,
  output logic [15:0]           packet_out_data,
  output logic [PKT_ADDR_W-1:0] packet_out_address,
  output logic                  packet_out_valid,
  input  logic                  periphery_gmem_access_failure_error,
  input  logic                  periphery_exception_error,
  input  logic [15:0]           periphery_exception_id,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [1:0]            fail_code
);

  typedef enum logic [3:0] {
    IDLE, HDR_RD, HDR_LAT, SIZE, BODY, EPI, SLP, CNT, RUN, DONE
  } state_t;

  state_t                state;
  logic [15:0]           size_q;
  logic [17:0]           body_left;
  logic                  rd_en_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic                  valid_q;
  logic [PKT_ADDR_W-1:0] pkt_addr_q;
  logic [15:0]           last_data_q;
  logic [15:0]           live_data;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic                  fail_q;
  logic [1:0]            code_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      size_q     <= '0;
      body_left  <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      pkt_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      code_q     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= HDR_RD;
            rd_en_q <= 1'b1;
            addr_q  <= MEM_ADDR_W'(HEADER_ADDR);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= '0;
          end
        end
        HDR_RD: begin
          rd_en_q <= 1'b0;
          state   <= HDR_LAT;
        end
        HDR_LAT: begin
          size_q <= mem_rdata;
          if (32'(mem_rdata) > MAX_PROGRAM) begin
            fail_q <= 1'b1;
            code_q <= 2'd3;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            // First body read overlaps the SIZE packet so body words stream gap-free
            state      <= SIZE;
            valid_q    <= 1'b1;
            pkt_addr_q <= '0;
            rd_en_q    <= (mem_rdata != 16'd0);
            addr_q     <= MEM_ADDR_W'(BODY_BASE);
          end
        end
        SIZE: begin
          if (size_q == 16'd0) begin
            state   <= EPI;
            rd_en_q <= 1'b0;
          end else begin
            state      <= BODY;
            pkt_addr_q <= PKT_ADDR_W'(1);
            body_left  <= {size_q, 2'b00};
            rd_en_q    <= 1'b1;
            addr_q     <= addr_q + 1'b1;
          end
        end
        BODY: begin
          if (body_left == 18'd1) begin
            state      <= EPI;
            pkt_addr_q <= '0;
            rd_en_q    <= 1'b0;
          end else begin
            // The word emitted in the final body cycle was already fetched, so stop reading early
            body_left <= body_left - 18'd1;
            rd_en_q   <= (body_left > 18'd2);
            if (body_left > 18'd2)
              addr_q <= addr_q + 1'b1;
          end
        end
        EPI: state <= SLP;
        SLP: state <= CNT;
        CNT: begin
          state   <= RUN;
          valid_q <= 1'b0;
        end
        RUN: begin
          if (periphery_gmem_access_failure_error) begin
            fail_q <= 1'b1;
            code_q <= 2'd2;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else if (periphery_exception_error) begin
            if (periphery_exception_id >= 16'h8000) begin
              fail_q <= 1'b1;
              code_q <= 2'd1;
            end else begin
              pass_q <= 1'b1;
            end
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Body words come straight from memory and EPI/SLP/CNT data is live, so data is muxed by state
  always_comb begin
    live_data = last_data_q;
    case (state)
      SIZE:    live_data = size_q;
      BODY:    live_data = mem_rdata;
      EPI:     live_data = epilogue_length;
      SLP:     live_data = sleep_length;
      CNT:     live_data = countdown;
      default: live_data = last_data_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      last_data_q <= '0;
    else
      last_data_q <= live_data;
  end

  assign mem_rd_en          = rd_en_q;
  assign mem_addr           = addr_q;
  assign packet_out_data    = live_data;
  assign packet_out_address = pkt_addr_q;
  assign packet_out_valid   = valid_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign fail               = fail_q;
  assign fail_code          = code_q;

endmodule

// File: tb/tb_boot_stream_loader.sv
// Randomized bench for boot_stream_loader: a packet-list model indexed by cycle offset
// from the start edge, checked every cycle, plus literal pins on the directed cases.
module tb_boot_stream_loader;

  localparam int MAXP  = 512;
  localparam int DEPTH = 2048;
  localparam int HDR   = 1;
  localparam int BASE  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] epilogue_length = '0;
  logic [15:0] sleep_length = '0;
  logic [15:0] countdown = '0;
  logic        mem_rd_en;
  logic [10:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] packet_out_data;
  logic [10:0] packet_out_address;
  logic        packet_out_valid;
  logic        gmem_err = 1'b0;
  logic        exc_err = 1'b0;
  logic [15:0] exc_id = '0;
  logic        busy, done, pass, fail;
  logic [1:0]  fail_code;

  boot_stream_loader #(
    .MEM_ADDR_W(11), .HEADER_ADDR(HDR), .BODY_BASE(BASE), .MAX_PROGRAM(MAXP), .PKT_ADDR_W(11)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .epilogue_length(epilogue_length), .sleep_length(sleep_length), .countdown(countdown),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .packet_out_data(packet_out_data), .packet_out_address(packet_out_address),
    .packet_out_valid(packet_out_valid),
    .periphery_gmem_access_failure_error(gmem_err),
    .periphery_exception_error(exc_err), .periphery_exception_id(exc_id),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_code(fail_code)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:DEPTH-1];
  always @(posedge clock) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  int rd_count = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (mem_rd_en) rd_count <= rd_count + 1;

  int n_cmp = 0;
  int n_bad = 0;

  bit          mon_on = 1'b0;
  bit          m_over = 1'b0;
  int          start_cyc = 0;
  int          m_size = 0;
  int          m_n = 0;
  int          pkt_seen = 0;
  logic [15:0] first_data = '0;
  logic [15:0] last_cnt = '0;
  bit          fixed_io = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected behaviour by cycle offset rel from the start edge: header read at rel 0,
  // packet k at rel 2+k, body word k-1 fetched at rel 1+k.
  always @(negedge clock) begin
    int rel, k;
    bit ev, erd;
    logic [15:0] ed;
    logic [10:0] ea;
    if (mon_on) begin
      rel = cyc - start_cyc;
      if (rel >= 0) begin
        chk("pass_fail_exclusive", {31'b0, pass & fail}, 32'd0);
        if (!m_over) begin
          ev = (rel >= 2) && (rel < 2 + m_n);
          chk("valid", {31'b0, packet_out_valid}, {31'b0, ev});
          if (ev) begin
            k = rel - 2;
            pkt_seen++;
            if (k == 0) begin
              ea = 11'd0; ed = 16'(m_size); first_data = packet_out_data;
            end else if (k <= 4 * m_size) begin
              ea = 11'd1; ed = mem[(BASE + k - 1) % DEPTH];
            end else if (k == m_n - 3) begin
              ea = 11'd0; ed = epilogue_length;
            end else if (k == m_n - 2) begin
              ea = 11'd0; ed = sleep_length;
            end else begin
              ea = 11'd0; ed = countdown; last_cnt = countdown;
            end
            chk("pkt_addr", {21'b0, packet_out_address}, {21'b0, ea});
            chk("pkt_data", {16'b0, packet_out_data}, {16'b0, ed});
          end else if (rel >= 2 + m_n) begin
            chk("hold_data", {16'b0, packet_out_data}, {16'b0, last_cnt});
            chk("hold_addr", {21'b0, packet_out_address}, 32'd0);
          end
          erd = (rel == 0) || (m_size != 0 && rel >= 2 && rel < 2 + 4 * m_size);
          chk("rd_en", {31'b0, mem_rd_en}, {31'b0, erd});
          if (erd)
            chk("mem_addr", {21'b0, mem_addr},
                (rel == 0) ? HDR : (BASE + rel - 2) % DEPTH);
          chk("busy", {31'b0, busy}, 32'd1);
          chk("done", {31'b0, done}, 32'd0);
          chk("pass", {31'b0, pass}, 32'd0);
          chk("fail", {31'b0, fail}, 32'd0);
        end else begin
          chk("ovr_valid", {31'b0, packet_out_valid}, 32'd0);
          chk("ovr_rd_en", {31'b0, mem_rd_en}, {31'b0, rel == 0});
          if (rel == 0) chk("ovr_mem_addr", {21'b0, mem_addr}, HDR);
          chk("ovr_busy", {31'b0, busy}, {31'b0, rel < 2});
          chk("ovr_done", {31'b0, done}, {31'b0, rel >= 2});
          chk("ovr_fail", {31'b0, fail}, {31'b0, rel >= 2});
          chk("ovr_code", {30'b0, fail_code}, (rel >= 2) ? 32'd3 : 32'd0);
          chk("ovr_pass", {31'b0, pass}, 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_io();
    if (!fixed_io) begin
      epilogue_length = 16'($urandom);
      sleep_length    = 16'($urandom);
      countdown       = 16'($urandom);
    end
    gmem_err = 1'($urandom);
    exc_err  = 1'($urandom);
    exc_id   = 16'($urandom);
  endtask

  // Starts a boot of the given size; reset_at >= 0 asserts reset at that offset and returns.
  task automatic boot(input int size, input int reset_at);
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    mem[HDR] = 16'(size);
    m_size   = size;
    m_over   = (size > MAXP);
    m_n      = m_over ? 0 : 4 * size + 4;
    pkt_seen = 0;
    rd_count = 0;
    start    = 1'b1;
    start_cyc = cyc + 1;
    mon_on   = 1'b1;
    tick();
    start = 1'b0;
    if (m_over) begin
      while (cyc - start_cyc < 3) begin rand_io(); tick(); end
      mon_on = 1'b0;
      gmem_err = 1'b0; exc_err = 1'b0;
      chk("ovr_final_done", {31'b0, done}, 32'd1);
      chk("ovr_final_code", {30'b0, fail_code}, 32'd3);
      chk("ovr_final_busy", {31'b0, busy}, 32'd0);
      return;
    end
    while (cyc - start_cyc < 2 + m_n) begin
      rand_io();
      start = ($urandom_range(0, 7) == 0);
      if (reset_at >= 0 && cyc - start_cyc == reset_at) begin
        start = 1'b0;
        reset = 1'b1;
        tick();
        mon_on = 1'b0;
        gmem_err = 1'b0; exc_err = 1'b0;
        return;
      end
      tick();
    end
    start = 1'b0; gmem_err = 1'b0; exc_err = 1'b0; exc_id = '0;
  endtask

  task automatic verdict(input int idle, input bit g, input bit e, input logic [15:0] id);
    bit ef, ep;
    logic [1:0] ec;
    logic p0, f0;
    logic [1:0] c0;
    repeat (idle) tick();
    gmem_err = g; exc_err = e; exc_id = id;
    tick();
    mon_on = 1'b0;
    gmem_err = 1'b0; exc_err = 1'b0;
    ef = g || (e && id >= 16'h8000);
    ep = !g && e && id < 16'h8000;
    ec = g ? 2'd2 : (ef ? 2'd1 : 2'd0);
    chk("v_done", {31'b0, done}, 32'd1);
    chk("v_busy", {31'b0, busy}, 32'd0);
    chk("v_pass", {31'b0, pass}, {31'b0, ep});
    chk("v_fail", {31'b0, fail}, {31'b0, ef});
    chk("v_code", {30'b0, fail_code}, {30'b0, ec});
    chk("v_valid", {31'b0, packet_out_valid}, 32'd0);
    p0 = ep; f0 = ef; c0 = ec;
    repeat (2) begin
      gmem_err = 1'($urandom); exc_err = 1'($urandom); exc_id = 16'($urandom);
      tick();
      chk("sticky_pass", {31'b0, pass}, {31'b0, p0});
      chk("sticky_fail", {31'b0, fail}, {31'b0, f0});
      chk("sticky_code", {30'b0, fail_code}, {30'b0, c0});
    end
    gmem_err = 1'b0; exc_err = 1'b0; exc_id = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'b0, packet_out_valid}, 32'd0);
    chk({tag, "_data"}, {16'b0, packet_out_data}, 32'd0);
    chk({tag, "_paddr"}, {21'b0, packet_out_address}, 32'd0);
    chk({tag, "_rd_en"}, {31'b0, mem_rd_en}, 32'd0);
    chk({tag, "_mem_addr"}, {21'b0, mem_addr}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_pass"}, {31'b0, pass}, 32'd0);
    chk({tag, "_fail"}, {31'b0, fail}, 32'd0);
    chk({tag, "_code"}, {30'b0, fail_code}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g, e;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Directed image: size 7, constant epilogue/sleep/countdown of 4
    fixed_io = 1'b1;
    epilogue_length = 16'd4; sleep_length = 16'd4; countdown = 16'd4;
    boot(7, -1);
    chk("plan_pkt_count", pkt_seen, 32'd32);
    chk("plan_first_data", {16'b0, first_data}, 32'd7);
    chk("plan_last_data", {16'b0, packet_out_data}, 32'd4);
    chk("plan_reads", rd_count, 32'd29);
    verdict(0, 1'b0, 1'b1, 16'h0002);
    chk("plan_pass", {31'b0, pass}, 32'd1);
    chk("plan_fail", {31'b0, fail}, 32'd0);

    boot(7, -1);
    verdict(2, 1'b0, 1'b1, 16'h8001);
    chk("exc_hi_fail", {31'b0, fail}, 32'd1);
    chk("exc_hi_code", {30'b0, fail_code}, 32'd1);

    boot(7, -1);
    verdict(1, 1'b1, 1'b1, 16'h0001);
    chk("gmem_code", {30'b0, fail_code}, 32'd2);
    chk("gmem_pass", {31'b0, pass}, 32'd0);

    boot(0, -1);
    chk("zero_pkts", pkt_seen, 32'd4);
    chk("zero_reads", rd_count, 32'd1);
    verdict(0, 1'b0, 1'b1, 16'h7fff);

    boot(600, -1);
    chk("ovr_reads", rd_count, 32'd1);
    boot(513, -1);
    fixed_io = 1'b0;

    // Largest legal program; body addresses wrap past the top of memory
    boot(512, -1);
    chk("max_pkts", pkt_seen, 32'd2052);
    verdict(0, 1'b0, 1'b1, 16'h8000);
    chk("id_8000_code", {30'b0, fail_code}, 32'd1);

    // Reset during the 10th body packet, then a full replay
    boot(7, 12);
    chk_all_zero("midrst");
    tick();
    reset = 1'b0;
    repeat (4) begin
      tick();
      chk("no_resume_valid", {31'b0, packet_out_valid}, 32'd0);
      chk("no_resume_rd", {31'b0, mem_rd_en}, 32'd0);
    end
    boot(7, -1);
    chk("replay_pkts", pkt_seen, 32'd32);
    verdict(0, 1'b0, 1'b1, 16'h0010);

    repeat (15) begin
      boot($urandom_range(0, 24), -1);
      g = ($urandom_range(0, 2) == 0);
      e = g ? 1'($urandom) : 1'b1;
      verdict($urandom_range(0, 3), g, e, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
